// File: rtl/uart_pkg.sv
// Shared types for the UART-side loader blocks: frame-decoder states
// and the default frame start marker.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_LO,
    S_ADDR_HI,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/uart_mem_loader.sv
// Decodes framed load commands from the UART byte stream into memory writes.
// Frame: SYNC ADDR_LO ADDR_HI LEN_LO LEN_HI DATA[LEN] CSUM (XOR, SYNC excluded).
// Ports:
//   i_Clock, i_Reset (async, active-high)
//   i_Rx_DV, i_Rx_Byte          : receiver strobe and byte
//   o_Mem_Addr/Data/We          : one-cycle write strobe, 1 clk after the byte
//   o_Busy                      : frame in progress
//   o_Done / o_Err              : one-cycle result pulses (checksum / timeout)
module uart_mem_loader
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CLKS = 100000,
  parameter int         TIMEOUT_W    = 17
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  output logic [15:0] o_Mem_Addr,
  output logic [7:0]  o_Mem_Data,
  output logic        o_Mem_We,
  output logic        o_Busy,
  output logic        o_Done,
  output logic        o_Err
);

  localparam logic [TIMEOUT_W-1:0] CNT_LAST =
    TIMEOUT_W'(TIMEOUT_CLKS - 1);

  state_e               state_q, state_d;
  logic [15:0]          addr_q, addr_d;
  logic [15:0]          len_q, len_d;
  logic [7:0]           csum_q, csum_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [15:0]          mem_addr_q, mem_addr_d;
  logic [7:0]           mem_data_q, mem_data_d;
  logic                 we_q, we_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 expire;
  logic [15:0]          len_new;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    csum_d     = csum_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    we_d       = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    len_new    = {i_Rx_Byte, len_q[7:0]};

    // An arriving byte beats a timeout expiring in the same cycle.
    expire = (state_q != S_IDLE) && !i_Rx_DV && (cnt_q == CNT_LAST);

    if ((state_q == S_IDLE) || i_Rx_DV) cnt_d = '0;
    else                               cnt_d = cnt_q + 1'b1;

    if (expire) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
    end else if (i_Rx_DV) begin
      unique case (state_q)
        S_IDLE: begin
          if (i_Rx_Byte == SYNC_BYTE) begin
            state_d = S_ADDR_LO;
            csum_d  = '0;
          end
        end
        S_ADDR_LO: begin
          addr_d[7:0] = i_Rx_Byte;
          csum_d      = csum_q ^ i_Rx_Byte;
          state_d     = S_ADDR_HI;
        end
        S_ADDR_HI: begin
          addr_d[15:8] = i_Rx_Byte;
          csum_d       = csum_q ^ i_Rx_Byte;
          state_d      = S_LEN_LO;
        end
        S_LEN_LO: begin
          len_d[7:0] = i_Rx_Byte;
          csum_d     = csum_q ^ i_Rx_Byte;
          state_d    = S_LEN_HI;
        end
        S_LEN_HI: begin
          len_d   = len_new;
          csum_d  = csum_q ^ i_Rx_Byte;
          state_d = (len_new == 16'd0) ? S_CSUM : S_DATA;
        end
        S_DATA: begin
          we_d       = 1'b1;
          mem_addr_d = addr_q;
          mem_data_d = i_Rx_Byte;
          addr_d     = addr_q + 16'd1;
          len_d      = len_q - 16'd1;
          csum_d     = csum_q ^ i_Rx_Byte;
          if (len_q == 16'd1) state_d = S_CSUM;
        end
        S_CSUM: begin
          state_d = S_IDLE;
          if (i_Rx_Byte == csum_q) done_d = 1'b1;
          else                     err_d  = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      csum_q     <= '0;
      cnt_q      <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      csum_q     <= csum_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      we_q       <= we_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign o_Mem_Addr = mem_addr_q;
  assign o_Mem_Data = mem_data_q;
  assign o_Mem_We   = we_q;
  assign o_Busy     = (state_q != S_IDLE);
  assign o_Done     = done_q;
  assign o_Err      = err_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Randomized self-checking bench for uart_mem_loader.
// Frames are built and their expected writes/results derived here.
module tb_uart_mem_loader;

  localparam int         T    = 64;
  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dv  = 1'b0;
  logic [7:0]  rx  = 8'h00;
  logic [15:0] addr;
  logic [7:0]  data;
  logic        we, busy, done, err;

  int n_chk = 0, n_fail = 0;
  int n_we = 0, n_done = 0, n_err = 0;
  int exp_we = 0, exp_done = 0, exp_err = 0;
  logic [7:0] pl[$];

  uart_mem_loader #(
    .SYNC_BYTE(SYNC), .TIMEOUT_CLKS(T), .TIMEOUT_W(17)
  ) dut (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_DV(dv), .i_Rx_Byte(rx),
    .o_Mem_Addr(addr), .o_Mem_Data(data), .o_Mem_We(we),
    .o_Busy(busy), .o_Done(done), .o_Err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (we) n_we++;
      if (done) n_done++;
      if (err) n_err++;
      if (done | err) check("done_err_overlap", 32'(done & err), 0);
    end
  end

  // xres: 0 none, 1 done expected, 2 err expected after this byte
  task automatic send_byte(input logic [7:0] b, input int gap,
                           input bit xwe, input logic [15:0] xa,
                           input bit xbusy, input int xres);
    repeat (gap) @(posedge clk);
    @(negedge clk);
    rx = b;
    dv = 1'b1;
    @(posedge clk);
    #1 dv = 1'b0;
    check("we", 32'(we), 32'(xwe));
    if (xwe) begin
      check("addr", 32'(addr), 32'(xa));
      check("data", 32'(data), 32'(b));
      exp_we++;
    end
    check("busy", 32'(busy), 32'(xbusy));
    check("done", 32'(done), 32'(xres == 1));
    check("err", 32'(err), 32'(xres == 2));
    if (xres == 1) exp_done++;
    if (xres == 2) exp_err++;
  endtask

  task automatic send_frame(input logic [15:0] a, input bit good,
                            input int gmax);
    logic [15:0] len;
    logic [7:0]  hdr[4];
    logic [7:0]  cs;
    int          w0;
    len = 16'(pl.size());
    hdr = '{a[7:0], a[15:8], len[7:0], len[15:8]};
    cs  = 8'h00;
    foreach (hdr[i]) cs ^= hdr[i];
    foreach (pl[i]) cs ^= pl[i];
    if (!good) cs = (cs == 8'h00) ? 8'h5A : 8'h00;
    w0 = n_we;
    send_byte(SYNC, $urandom_range(gmax, 0), 0, 0, 1, 0);
    foreach (hdr[i])
      send_byte(hdr[i], $urandom_range(gmax, 0), 0, 0, 1, 0);
    foreach (pl[i])
      send_byte(pl[i], $urandom_range(gmax, 0), 1, a + 16'(i), 1, 0);
    send_byte(cs, $urandom_range(gmax, 0), 0, 0, 0, good ? 1 : 2);
    check("frame_writes", 32'(n_we - w0), 32'(pl.size()));
  endtask

  initial begin
    int e0;
    logic [7:0] cs;
    #12;
    check("rst_addr", 32'(addr), 0);
    check("rst_data", 32'(data), 0);
    check("rst_we", 32'(we), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    @(negedge clk) rst = 1'b0;

    pl = '{8'h11, 8'h22, 8'h33};
    send_frame(16'hC000, 1, 2);
    send_frame(16'hC000, 0, 2);
    pl = '{};
    send_frame(16'h1234, 1, 1);
    pl = '{8'hAA, 8'hBB};
    send_frame(16'hFFFF, 1, 1);

    for (int f = 0; f < 12; f++) begin
      int n;
      n = $urandom_range(6, 0);
      pl = '{};
      for (int i = 0; i < n; i++)
        pl.push_back(($urandom_range(3, 0) == 0) ? SYNC : 8'($urandom));
      send_frame(16'($urandom), $urandom_range(3, 0) != 0, 3);
    end

    // truncated frame: silence until the inter-byte timeout fires
    send_byte(SYNC, 0, 0, 0, 1, 0);
    send_byte(8'h00, 0, 0, 0, 1, 0);
    send_byte(8'h10, 0, 0, 0, 1, 0);
    send_byte(8'h05, 0, 0, 0, 1, 0);
    send_byte(8'h00, 0, 0, 0, 1, 0);
    send_byte(8'h01, 0, 1, 16'h1000, 1, 0);
    e0 = n_err;
    repeat (T - 1) @(posedge clk);
    #1;
    check("to_early_busy", 32'(busy), 1);
    check("to_early_err", 32'(err), 0);
    @(posedge clk);
    #1;
    check("to_err", 32'(err), 1);
    check("to_busy", 32'(busy), 0);
    exp_err++;
    repeat (4) @(posedge clk);
    #1;
    check("to_err_once", 32'(n_err - e0), 1);
    pl = '{8'h5C, SYNC, 8'h07};
    send_frame(16'h1000, 1, 2);

    // byte arriving on the cycle the timeout would expire wins
    cs = 8'h34 ^ 8'h12 ^ 8'h01 ^ 8'h00 ^ 8'h77;
    send_byte(SYNC, 0, 0, 0, 1, 0);
    send_byte(8'h34, 0, 0, 0, 1, 0);
    send_byte(8'h12, 0, 0, 0, 1, 0);
    send_byte(8'h01, 0, 0, 0, 1, 0);
    send_byte(8'h00, 0, 0, 0, 1, 0);
    send_byte(8'h77, T - 1, 1, 16'h1234, 1, 0);
    send_byte(cs, T - 1, 0, 0, 0, 1);

    // reset in the middle of DATA aborts silently
    send_byte(SYNC, 0, 0, 0, 1, 0);
    send_byte(8'h00, 0, 0, 0, 1, 0);
    send_byte(8'h20, 0, 0, 0, 1, 0);
    send_byte(8'h04, 0, 0, 0, 1, 0);
    send_byte(8'h00, 0, 0, 0, 1, 0);
    send_byte(8'hAA, 0, 1, 16'h2000, 1, 0);
    send_byte(8'hBB, 1, 1, 16'h2001, 1, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_addr", 32'(addr), 0);
    check("mid_rst_data", 32'(data), 0);
    check("mid_rst_busy", 32'(busy), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    e0 = n_done + n_err;
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_pulses", 32'(n_done + n_err - e0), 0);
    send_byte(8'h00, 1, 0, 0, 0, 0);
    send_byte(8'hFF, 1, 0, 0, 0, 0);
    pl = '{8'h01};
    send_frame(16'h0042, 1, 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("total_writes", 32'(n_we), 32'(exp_we));
    check("total_done", 32'(n_done), 32'(exp_done));
    check("total_err", 32'(n_err), 32'(exp_err));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_mem_loader.md
Name: uart_mem_loader

Overview:
Consumes the byte stream from the UART receiver (one-cycle valid strobe plus byte) and decodes framed load commands. Each frame writes a run of bytes into C64-side memory through a single-cycle write strobe. An XOR checksum validates each frame, and an inter-byte timeout recovers from truncated frames. The block sits directly downstream of the UART receiver and upstream of the memory arbiter / RAM write port.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker; all bytes other than this are ignored in IDLE.
TIMEOUT_CLKS, 100000, clocks allowed between bytes inside a frame before abort.
TIMEOUT_W, 17, counter width; must satisfy 2^TIMEOUT_W > TIMEOUT_CLKS.

Ports:
i_Clock  in  1  system clock, same domain as the UART receiver.
i_Reset  in  1  asynchronous, active-high reset.
i_Rx_DV  in  1  one-cycle strobe: i_Rx_Byte is valid.
i_Rx_Byte  in  8  received byte.
o_Mem_Addr  out  16  write address.
o_Mem_Data  out  8  write data.
o_Mem_We  out  1  one-cycle write strobe; memory must accept in that cycle.
o_Busy  out  1  high while a frame is in progress (state != IDLE).
o_Done  out  1  one-cycle pulse: frame complete, checksum good.
o_Err  out  1  one-cycle pulse: checksum mismatch or timeout.

Behaviour:
- Reset (async, i_Reset=1): state IDLE; o_Mem_Addr=0, o_Mem_Data=0, o_Mem_We=0, o_Busy=0, o_Done=0, o_Err=0; checksum, length and timeout counters cleared.
- Frame format: SYNC, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, DATA[0..LEN-1], CSUM.
- CSUM is the XOR of every byte from ADDR_LO through the last DATA byte. SYNC is excluded.
- State machine, advancing only on i_Rx_DV:
  - IDLE -> ADDR_LO when byte == SYNC_BYTE; any other byte is discarded.
  - ADDR_LO -> ADDR_HI -> LEN_LO -> LEN_HI.
  - LEN_HI -> DATA if assembled LEN != 0, else -> CSUM.
  - DATA stays in DATA until the remaining count reaches 0, then -> CSUM.
  - CSUM -> IDLE.
- Data writes: on each DATA byte's i_Rx_DV, the next cycle drives o_Mem_We=1 with o_Mem_Addr = current address and o_Mem_Data = the byte. Address then increments, wrapping 16'hFFFF -> 16'h0000. Latency from i_Rx_DV to o_Mem_We is exactly 1 clock.
- o_Mem_Addr/o_Mem_Data hold their last values between strobes.
- Checksum check: on the CSUM byte, one cycle later, o_Done=1 if it matches the running XOR, else o_Err=1. Exactly one of the two pulses fires per frame.
- Writes are not rolled back on error; the host retransmits the frame.
- o_Busy = 1 in every state except IDLE, updated on the same edge as the state register.
- Timeout: the counter clears on every i_Rx_DV and counts while not in IDLE. On reaching TIMEOUT_CLKS-1: o_Err pulses, state -> IDLE, and no further writes occur.
- Boundary conditions:
  - If i_Rx_DV arrives in the same cycle the timeout would expire, the byte wins and the counter is cleared.
  - A SYNC_BYTE value inside the payload is ordinary data; there is no resync inside a frame.
  - LEN=16'hFFFF is legal (65535 writes). LEN=0 produces no writes.
  - o_Done and o_Err never overlap.
  - Reset asserted mid-frame aborts the frame immediately; no Done or Err pulse is produced.
  - Because the UART delivers bytes at least 10*CLKS_PER_BIT clocks apart, no input buffering is needed.

Decomposition:
- Shared package uart_pkg holds the state encodings (S_IDLE, S_ADDR_LO, S_ADDR_HI, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM) and the default SYNC_BYTE constant.
- No sub-module is required. The timeout counter may be split out as uart_timeout (load/clear, expire pulse) if reused by the transmitter-side command responder.

Test Plan:
1. Frame A5 00 C0 03 00 11 22 33 and CSUM=(00^C0^03^00^11^22^33) -> three o_Mem_We pulses at addresses C000/C001/C002 with data 11/22/33, each 1 clk after its DV; then o_Done=1 for one clock; o_Busy drops.
2. Same frame with CSUM byte 00 -> three writes still occur, then o_Err=1, o_Done stays 0.
3. LEN=0 frame A5 34 12 00 00 CSUM=26 -> no writes, o_Done pulse.
4. Address wrap: A5 FF FF 02 00 AA BB CSUM -> writes at FFFF then 0000.
5. Timeout: send A5 00 10 05 00 01, then silence TIMEOUT_CLKS clocks -> exactly one o_Err pulse, state IDLE. A following valid frame completes normally.
6. Reset mid-DATA; garbage bytes 00 FF in IDLE -> after reset all outputs 0 and no pulses; garbage bytes are ignored with o_Busy staying 0.
